// File: rtl/fetch_queue_pkg.sv
// Shared fetch-unit types: queue entry layout and default geometry.
package FetchUnitTypes;

  localparam int FETCH_QUEUE_DEPTH = 8;
  localparam int FETCH_QUEUE_INDEX = $clog2(FETCH_QUEUE_DEPTH);

  localparam int FQ_PC_WIDTH   = 32;
  localparam int FQ_INSN_WIDTH = 32;
  localparam int FQ_HIST_WIDTH = 10;

  typedef struct packed {
    logic [FQ_PC_WIDTH-1:0]   pc;
    logic [FQ_INSN_WIDTH-1:0] insn;
    logic                     br_pred_taken;
    logic [FQ_HIST_WIDTH-1:0] br_hist;
  } FetchQueueEntry;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Head/tail pointers and occupancy for the fetch queue circular buffer.
module fetch_queue_ctrl
  import FetchUnitTypes::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int OUT_WIDTH   = 2,
  parameter int DEPTH       = FETCH_QUEUE_DEPTH,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int POP_W      = $clog2(OUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [FETCH_WIDTH-1:0] in_valid,
  input  logic [POP_W-1:0]       pop_count,
  output logic [IDX_W-1:0]       head,
  output logic [IDX_W-1:0]       tail,
  output logic [CNT_W-1:0]       count,
  output logic                   in_ready,
  output logic                   push_en
);

  logic [CNT_W-1:0] push_num;
  logic [CNT_W-1:0] pushed;
  logic [CNT_W-1:0] popped;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] count_next;
  logic [IDX_W-1:0] head_next;
  logic [IDX_W-1:0] tail_next;

  // Readiness depends on registered occupancy only; a same-cycle pop never frees room.
  assign in_ready = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign push_en  = in_ready & in_valid[0];
  assign avail    = (count < CNT_W'(OUT_WIDTH)) ? count : CNT_W'(OUT_WIDTH);

  always_comb begin
    push_num = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      push_num = push_num + CNT_W'(in_valid[k]);
    end
  end

  always_comb begin
    pushed     = push_en ? push_num : '0;
    popped     = (CNT_W'(pop_count) > avail) ? avail : CNT_W'(pop_count);
    count_next = count + pushed - popped;
    head_next  = head + IDX_W'(popped);
    tail_next  = tail + IDX_W'(pushed);
    if (flush) begin
      count_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Consumer must never pop more than the valid output lanes.
  always_ff @(posedge clk) begin
    if (rst && count != '0) begin
      assert (CNT_W'(pop_count) <= avail);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Multi-lane fetch queue: entry storage and lane muxing around fetch_queue_ctrl.
module fetch_queue
  import FetchUnitTypes::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int OUT_WIDTH   = 2,
  parameter int DEPTH       = FETCH_QUEUE_DEPTH,
  parameter int PC_WIDTH    = FQ_PC_WIDTH,
  parameter int INSN_WIDTH  = FQ_INSN_WIDTH,
  parameter int HIST_WIDTH  = FQ_HIST_WIDTH,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int POP_W      = $clog2(OUT_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [FETCH_WIDTH-1:0]            inValid,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]   inPC,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] inInsn,
  input  logic [FETCH_WIDTH-1:0]            inBrPredTaken,
  input  logic [FETCH_WIDTH*HIST_WIDTH-1:0] inBrHist,
  output logic                              inReady,
  output logic [OUT_WIDTH-1:0]              outValid,
  output logic [OUT_WIDTH*PC_WIDTH-1:0]     outPC,
  output logic [OUT_WIDTH*INSN_WIDTH-1:0]   outInsn,
  output logic [OUT_WIDTH-1:0]              outBrPredTaken,
  output logic [OUT_WIDTH*HIST_WIDTH-1:0]   outBrHist,
  input  logic [POP_W-1:0]                  popCount,
  output logic [CNT_W-1:0]                  count
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INSN_WIDTH-1:0] insn;
    logic                  br_pred_taken;
    logic [HIST_WIDTH-1:0] br_hist;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry [FETCH_WIDTH];
  logic [IDX_W-1:0] wr_addr [FETCH_WIDTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic             push_en;

  fetch_queue_ctrl #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .DEPTH       (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inValid),
    .pop_count (popCount),
    .head      (head),
    .tail      (tail),
    .count     (count),
    .in_ready  (inReady),
    .push_en   (push_en)
  );

  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr
    assign wr_addr[gi]  = tail + IDX_W'(gi);
    assign wr_entry[gi] = '{pc:            inPC[gi*PC_WIDTH +: PC_WIDTH],
                            insn:          inInsn[gi*INSN_WIDTH +: INSN_WIDTH],
                            br_pred_taken: inBrPredTaken[gi],
                            br_hist:       inBrHist[gi*HIST_WIDTH +: HIST_WIDTH]};
  end

  // Storage is not reset; a write during flush lands in space that flush invalidates.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (inValid[k]) mem[wr_addr[k]] <= wr_entry[k];
      end
    end
  end

  for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_rd
    logic [IDX_W-1:0] rd_addr;
    entry_t           rd_entry;
    assign rd_addr                                 = head + IDX_W'(gi);
    assign rd_entry                                = mem[rd_addr];
    assign outValid[gi]                            = (count > CNT_W'(gi));
    assign outPC[gi*PC_WIDTH +: PC_WIDTH]          = rd_entry.pc;
    assign outInsn[gi*INSN_WIDTH +: INSN_WIDTH]    = rd_entry.insn;
    assign outBrPredTaken[gi]                      = rd_entry.br_pred_taken;
    assign outBrHist[gi*HIST_WIDTH +: HIST_WIDTH]  = rd_entry.br_hist;
  end

  // Push lanes must be packed from lane 0 (valid mask of the form 2^n-1).
  always_ff @(posedge clk) begin
    if (rst) begin
      assert ((inValid & (inValid + FETCH_WIDTH'(1))) == '0);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + light random bench for fetch_queue using a queue scoreboard.
module tb_fetch_queue;

  localparam int FW = 2;
  localparam int OW = 2;
  localparam int D  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  inValid = '0;
  logic [63:0] inPC = '0;
  logic [63:0] inInsn = '0;
  logic [1:0]  inBrPredTaken = '0;
  logic [19:0] inBrHist = '0;
  logic        inReady;
  logic [1:0]  outValid;
  logic [63:0] outPC;
  logic [63:0] outInsn;
  logic [1:0]  outBrPredTaken;
  logic [19:0] outBrHist;
  logic [1:0]  popCount = '0;
  logic [3:0]  count;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .inValid        (inValid),
    .inPC           (inPC),
    .inInsn         (inInsn),
    .inBrPredTaken  (inBrPredTaken),
    .inBrHist       (inBrHist),
    .inReady        (inReady),
    .outValid       (outValid),
    .outPC          (outPC),
    .outInsn        (outInsn),
    .outBrPredTaken (outBrPredTaken),
    .outBrHist      (outBrHist),
    .popCount       (popCount),
    .count          (count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        pred;
    logic [9:0]  hist;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic exp_t mk(logic [31:0] pc);
    exp_t r;
    r.pc   = pc;
    r.insn = ~pc ^ 32'h1357_0000;
    r.pred = pc[3];
    r.hist = pc[11:2] ^ 10'h2A5;
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag);
    int n;
    n = sb.size();
    chk({tag, " count"}, 64'(count), 64'(n));
    chk({tag, " inReady"}, 64'(inReady), 64'((D - n) >= FW));
    chk({tag, " outValid"}, 64'(outValid), 64'({n > 1, n > 0}));
    for (int i = 0; i < OW; i++) begin
      if (i < n) begin
        exp_t e;
        e = sb[i];
        chk({tag, $sformatf(" pc%0d", i)},   64'(outPC[i*32 +: 32]),   64'(e.pc));
        chk({tag, $sformatf(" insn%0d", i)}, 64'(outInsn[i*32 +: 32]), 64'(e.insn));
        chk({tag, $sformatf(" pred%0d", i)}, 64'(outBrPredTaken[i]),   64'(e.pred));
        chk({tag, $sformatf(" hist%0d", i)}, 64'(outBrHist[i*10 +: 10]), 64'(e.hist));
      end
    end
    $display("step %-16s count=%0d inReady=%0b outValid=%02b pc0=%0h pc1=%0h",
             tag, count, inReady, outValid, outPC[31:0], outPC[63:32]);
  endtask

  task automatic drive(logic [1:0] v, logic [31:0] pc0, logic [31:0] pc1,
                       logic [1:0] pop, logic fl);
    exp_t e0;
    exp_t e1;
    e0 = mk(pc0);
    e1 = mk(pc1);
    inValid       = v;
    inPC          = {pc1, pc0};
    inInsn        = {e1.insn, e0.insn};
    inBrPredTaken = {e1.pred, e0.pred};
    inBrHist      = {e1.hist, e0.hist};
    popCount      = pop;
    flush         = fl;
  endtask

  // One clock: predict from pre-edge model state, then check after the edge.
  task automatic cycle(string tag, logic [1:0] v, logic [31:0] pc0, logic [31:0] pc1,
                       logic [1:0] pop, logic fl);
    int  n;
    bit  acc;
    n   = sb.size();
    acc = ((D - n) >= FW) && v[0];
    drive(v, pc0, pc1, pop, fl);
    if (fl) begin
      sb.delete();
    end else begin
      for (int i = 0; i < int'(pop); i++) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (acc) begin
        sb.push_back(mk(pc0));
        if (v[1]) sb.push_back(mk(pc1));
      end
    end
    @(posedge clk);
    #1;
    inValid  = '0;
    popCount = '0;
    flush    = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #3;
    check_state("reset");
    @(negedge clk);
    rst = 1'b1;

    cycle("r050_push", 2'b11, 32'h100, 32'h104, 2'd0, 1'b0);
    cycle("drain", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    cycle("flush_idle", 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      cycle("r051_fill", 2'b11, 32'h300 + 32'(k * 16), 32'h304 + 32'(k * 16), 2'd0, 1'b0);
    end
    cycle("r051_full_push", 2'b11, 32'h380, 32'h384, 2'd0, 1'b0);
    cycle("r052_pop", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    cycle("r052_wrap_push", 2'b11, 32'h390, 32'h394, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle("r052_drain", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    end

    cycle("r053_a", 2'b11, 32'h500, 32'h504, 2'd0, 1'b0);
    cycle("r053_b", 2'b01, 32'h508, 32'h0, 2'd0, 1'b0);
    cycle("r053_pushpop", 2'b01, 32'h50c, 32'h0, 2'd1, 1'b0);

    cycle("r054_a", 2'b11, 32'h600, 32'h604, 2'd0, 1'b0);
    cycle("r054_flush", 2'b11, 32'h610, 32'h614, 2'd2, 1'b1);
    cycle("r054_push", 2'b01, 32'h200, 32'h0, 2'd0, 1'b0);

    cycle("r055_a", 2'b11, 32'h700, 32'h704, 2'd0, 1'b0);
    cycle("r055_b", 2'b01, 32'h708, 32'h0, 2'd0, 1'b0);
    // Assert reset mid-cycle while a push is being presented.
    drive(2'b11, 32'h710, 32'h714, 2'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    check_state("r055_async");
    @(negedge clk);
    rst = 1'b1;
    inValid = '0;
    check_state("r055_release");
    cycle("r055_first_push", 2'b11, 32'h400, 32'h404, 2'd0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      int         n;
      int         sel;
      logic [1:0] v;
      logic [1:0] pop;
      n   = sb.size();
      sel = int'($urandom_range(0, 2));
      v   = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      pop = 2'($urandom_range(0, (n < 2) ? n : 2));
      cycle("random", v, 32'h1000 + 32'(k * 8), 32'h1004 + 32'(k * 8), pop, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be: FETCH_WIDTH, default 2, push lanes per cycle; OUT_WIDTH, default 2, pop lanes per cycle; DEPTH, default 8, entries (power of 2, DEPTH >= max(FETCH_WIDTH,OUT_WIDTH)); PC_WIDTH, default 32; INSN_WIDTH, default 32; HIST_WIDTH, default 10.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name  direction  width  meaning):
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  branch redirect; discard all contents
inValid  in  FETCH_WIDTH  per-lane push valid, contiguous from lane 0
inPC  in  FETCH_WIDTH*PC_WIDTH  per-lane PC
inInsn  in  FETCH_WIDTH*INSN_WIDTH  per-lane instruction word
inBrPredTaken  in  FETCH_WIDTH  per-lane predicted-taken
inBrHist  in  FETCH_WIDTH*HIST_WIDTH  per-lane global history snapshot
inReady  out  1  free entries >= FETCH_WIDTH
outValid  out  OUT_WIDTH  lane i valid iff count > i
outPC  out  OUT_WIDTH*PC_WIDTH  oldest-first PCs
outInsn  out  OUT_WIDTH*INSN_WIDTH  oldest-first instructions
outBrPredTaken  out  OUT_WIDTH  oldest-first prediction
outBrHist  out  OUT_WIDTH*HIST_WIDTH  oldest-first history
popCount  in  clog2(OUT_WIDTH+1)  entries consumed this cycle
count  out  clog2(DEPTH+1)  current occupancy

Function
REQ-010 Storage SHALL be a circular buffer of DEPTH entries {PC, insn, brPredTaken, brHist} with head, tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-011 Push SHALL occur when inReady=1 and inValid[0]=1; exactly popcount(inValid) entries written, lane 0 at tail, lane k at tail+k mod DEPTH.
REQ-012 Push is all-or-nothing: when inReady=0 no lane SHALL be written; producer holds data.
REQ-013 Non-contiguous inValid (lane k valid, lane k-1 invalid) is illegal; verification SHALL flag it by assertion.
REQ-014 inReady SHALL be computed from registered count only (no combinational path from popCount).
REQ-015 Outputs SHALL be driven from entries head..head+OUT_WIDTH-1 registered state; write-to-read latency is one cycle (no bypass).
REQ-016 Pop SHALL advance head by popCount; popCount > number of set outValid bits is illegal and SHALL be flagged by assertion.
REQ-017 Simultaneous push and pop SHALL both take effect; count_next = count + pushed - popped.
REQ-018 Full (count=DEPTH) with pop in same cycle: inReady still reflects registered count, so push waits one cycle.
REQ-019 Empty: all outValid=0; popCount ignored.
REQ-020 flush=1 SHALL set head=tail=0, count=0 at next edge; simultaneous push and pop that cycle are discarded.
REQ-021 Entry data need not be cleared on flush; invalid lanes' data are don't-care.

Reset
REQ-030 rst low SHALL immediately force head=0, tail=0, count=0, outValid=0, inReady=1 (given DEPTH >= FETCH_WIDTH).
REQ-031 Reset mid-operation SHALL discard all entries; first push after rst release is accepted on the first rising edge.
REQ-032 Entry storage SHALL not be reset (RAM-inferable).

Structure
REQ-040 FetchQueueEntry struct, FETCH_QUEUE_DEPTH and FETCH_QUEUE_INDEX width constants SHALL live in FetchUnitTypes package.
REQ-041 Pointer/occupancy logic SHALL be a sub-module fetch_queue_ctrl; storage and lane muxing stay in fetch_queue.

Verification (FETCH_WIDTH=2, OUT_WIDTH=2, DEPTH=8)
REQ-050 Reset, push {PC 0x100, 0x104} -> next cycle count=2, outValid=11, outPC={0x100,0x104}.
REQ-051 Push 2/cycle with popCount=0 for 4 cycles -> count=8, inReady=0; fifth push not written, count stays 8.
REQ-052 Full, popCount=2 -> count=6, inReady=1 next cycle; push then accepted, tail wraps to 0 and order preserved oldest-first.
REQ-053 count=3, push 1 lane (inValid=01) with popCount=1 same cycle -> count=3, output head advanced by 1.
REQ-054 count=5, flush=1 with push and popCount=2 -> count=0, outValid=00, inReady=1; next push of PC 0x200 appears at outPC lane 0.
REQ-055 Drive rst low during push with count=4 -> count=0, outValid=00 immediately, no entry visible after release.
